// File: rtl/cpu_pkg.sv
// Shared CPU definitions: shift opcodes, the shift-op enum used by the ALU decoder,
// and the iterative shifter FSM state encoding.
package cpu_pkg;

  localparam logic [4:0] SHL  = 5'b00101;
  localparam logic [4:0] SHR  = 5'b00110;
  localparam logic [4:0] SHRA = 5'b00111;
  localparam logic [4:0] ROR  = 5'b01000;
  localparam logic [4:0] ROL  = 5'b01001;

  typedef enum logic [4:0] {
    OP_SHL  = 5'b00101,
    OP_SHR  = 5'b00110,
    OP_SHRA = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

  function automatic logic is_shift_op(input logic [4:0] code);
    return (code == SHL) || (code == SHR) || (code == SHRA) ||
           (code == ROR) || (code == ROL);
  endfunction

  function automatic logic is_rotate_op(input logic [4:0] code);
    return (code == ROR) || (code == ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: shifts or rotates value by s (0..STEP) per op.
module shift_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SW-1:0]    s,
  input  shift_op_e        op,
  input  logic             sign,
  output logic [WIDTH-1:0] shifted
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] ext;
  logic [2*WIDTH-1:0] wide;

  // Double-width operands turn arithmetic shift and rotates into plain shifts.
  always_comb begin
    dbl     = {value, value};
    ext     = {{WIDTH{sign}}, value};
    wide    = '0;
    shifted = value;
    case (op)
      OP_SHL:  shifted = value << s;
      OP_SHR:  shifted = value >> s;
      OP_SHRA: begin
        wide    = ext >> s;
        shifted = wide[WIDTH-1:0];
      end
      OP_ROR: begin
        wide    = dbl >> s;
        shifted = wide[WIDTH-1:0];
      end
      OP_ROL: begin
        wide    = dbl << s;
        shifted = wide[2*WIDTH-1:WIDTH];
      end
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: up to STEP bits per cycle, start/busy/done handshake.
// Handshake: a request is taken on any edge with start=1 while busy=0; done pulses
// for one cycle with result/err valid, and both hold until the next accepted request.
module iterative_shifter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [4:0]       op_code,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] shamt_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output shift_state_e     dbg_state
);

  localparam int LW = $clog2(WIDTH);
  localparam int SW = $clog2(STEP) + 1;
  localparam logic [AMT_W-1:0] FULL_AMT = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [AMT_W-1:0] count_q;
  shift_op_e        op_q;
  logic             sign_q;
  logic             err_next_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  logic             accept;
  logic             legal;
  logic [AMT_W-1:0] amt;
  logic [AMT_W-1:0] step_amt;
  logic [WIDTH-1:0] step_out;

  // Shift amounts saturate at WIDTH; rotate amounts wrap modulo WIDTH.
  always_comb begin
    legal = is_shift_op(op_code);
    amt   = '0;
    if (legal) begin
      if (is_rotate_op(op_code))
        amt = {1'b0, shamt_in[LW-1:0]};
      else if (|shamt_in[WIDTH-1:LW])
        amt = FULL_AMT;
      else
        amt = {1'b0, shamt_in[LW-1:0]};
    end
  end

  always_comb begin
    step_amt = (count_q < STEP_AMT) ? count_q : STEP_AMT;
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value   (work_q),
    .s       (step_amt[SW-1:0]),
    .op      (op_q),
    .sign    (sign_q),
    .shifted (step_out)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      work_q     <= '0;
      count_q    <= '0;
      op_q       <= OP_SHL;
      sign_q     <= 1'b0;
      err_next_q <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      work_q     <= data_in;
      count_q    <= amt;
      op_q       <= shift_op_e'(op_code);
      sign_q     <= data_in[WIDTH-1];
      err_next_q <= ~legal;
    end else if (state_q == ST_SHIFT) begin
      if (count_q == '0) begin
        result_q <= work_q;
        err_q    <= err_next_q;
      end else begin
        work_q  <= step_out;
        count_q <= count_q - step_amt;
      end
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule
